uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
Controller between the UART receiver and the edge-detector pixel RAM. It parses a framed image stream from received bytes, writes the pixels sequentially into the frame RAM and starts the edge-detection core. It then holds off new frames until the core reports completion. It also detects malformed frames, inter-byte timeouts and bytes that arrive while the core is busy.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
ADDR_W, 14, pixel RAM address width
MAX_PIXELS, 16384, maximum W*H accepted (must be <= 2**ADDR_W)
TIMEOUT_CLKS, 1000000, idle clocks between bytes before a frame is aborted (20 ms at 50 MHz)

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Rx_DV  in  1  one-cycle byte-valid strobe from UART receiver
i_Rx_Byte  in  8  received byte, valid while i_Rx_DV=1
o_Wr_En  out  1  pixel RAM write strobe
o_Wr_Addr  out  ADDR_W  pixel RAM write address
o_Wr_Data  out  8  pixel RAM write data
o_Width  out  8  latched frame width
o_Height  out  8  latched frame height
o_Proc_Start  out  1  one-cycle start pulse to edge detector
i_Proc_Done  in  1  edge detector completion (level or pulse)
o_Busy  out  1  high in every state except IDLE
o_Frame_Err  out  1  one-cycle error pulse
o_Err_Code  out  2  01 size, 10 timeout, 11 overrun; holds last value

Behaviour:
- Clock and reset: one clock, i_Clock. Reset is asynchronous and active-low on i_Rst_n.
- Reset values: state=IDLE. All outputs are 0, including counters, o_Width, o_Height and o_Err_Code.
- Frame format: SYNC_BYTE, W, H, then W*H pixel bytes in raster order.
- IDLE: on DV with byte==SYNC_BYTE go to GET_W. Any other byte is ignored with no error.
- GET_W: on DV, latch o_Width and go to GET_H.
- GET_H: on DV, latch o_Height and go to CHECK.
- CHECK (one cycle): compute W*H as a 16-bit product and store it as the pixel count.
  - If W==0, H==0 or product>MAX_PIXELS: pulse o_Frame_Err, set o_Err_Code=01, go to IDLE.
  - Otherwise clear the address counter and go to LOAD.
- LOAD: each DV produces a write exactly one cycle later: o_Wr_En=1, o_Wr_Data=the byte, o_Wr_Addr=current count. The count then increments.
  - After the write of pixel count-1, go to START. No wrap-around.
- START (one cycle): o_Proc_Start=1, then go to BUSY.
- BUSY: wait for i_Proc_Done=1, then go to IDLE. i_Proc_Done is sampled only in BUSY.
- Overrun: a DV in CHECK, START or BUSY is dropped. It pulses o_Frame_Err with o_Err_Code=11 and the state is unchanged.
- Timeout counter: runs in GET_W, GET_H and LOAD and clears on every DV.
  - On reaching TIMEOUT_CLKS-1: pulse o_Frame_Err, set o_Err_Code=10, go to IDLE.
  - If DV and the terminal count coincide, the DV wins: the byte is accepted and the counter cleared.
  - The counter is held at 0 in all other states.
- Pixel bytes equal to SYNC_BYTE are ordinary data inside LOAD; resync only happens in IDLE.
- Reset asserted mid-frame: immediate return to IDLE, outputs cleared, o_Wr_En deasserted in the same instant. The RAM contents are not cleared.
- o_Wr_En and o_Proc_Start are never high in the same cycle.
- o_Width and o_Height hold their values until the next accepted header.

Test Plan:
- Frame A5 04 02 followed by pixels 10..17 -> 8 writes at addr 0..7 with data 0x10..0x17, each one cycle after its DV. o_Width=4, o_Height=2. o_Proc_Start pulses once, one cycle after the addr-7 write. o_Busy stays high until i_Proc_Done, then returns to 0.
- Bytes 00 FF 5A, then a valid 2x2 frame (A5 02 02 A5 01 02 03) -> extra bytes ignored. Writes go to addr 0..3 with data A5,01,02,03 (in-frame A5 treated as data). No error.
- Header A5 00 05 -> o_Frame_Err pulse with o_Err_Code=01, no writes, IDLE. Repeat with A5 C8 64 (20000 > 16384) -> same response.
- TIMEOUT_CLKS=1000: A5 03 03 followed by 3 pixels, then silence -> o_Frame_Err with o_Err_Code=10 exactly 1000 clocks after the last DV, o_Busy=0. A subsequent valid frame loads from addr 0.
- During BUSY, send byte 0x55 -> o_Frame_Err with code 11, no write. Then assert i_Proc_Done -> IDLE.
- Assert i_Rst_n=0 after 2 pixels of a 4x4 frame -> all outputs 0 asynchronously. After release, a full 4x4 frame loads at addr 0..15.

Source files
------------

// File: rtl/uart_frame_loader.sv
// Parses SYNC/W/H/pixel frames from the UART byte stream, writes pixels into the
// frame RAM, then starts the edge detector and waits for it to finish.
module uart_frame_loader #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         ADDR_W       = 14,
  parameter int         MAX_PIXELS   = 16384,
  parameter int         TIMEOUT_CLKS = 1000000
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic [7:0]        o_Width,
  output logic [7:0]        o_Height,
  output logic              o_Proc_Start,
  input  logic              i_Proc_Done,
  output logic              o_Busy,
  output logic              o_Frame_Err,
  output logic [1:0]        o_Err_Code
);

  localparam int              TO_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]     MAX_P   = 17'(MAX_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_W, S_GET_H, S_CHECK, S_LOAD, S_START, S_BUSY
  } state_t;

  state_t            r_state, w_state_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic [15:0]       r_pix_cnt;
  logic [15:0]       r_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_width;
  logic [7:0]        r_height;
  logic              r_frame_err;
  logic [1:0]        r_err_code;

  logic [15:0] w_product;
  logic        w_size_bad;
  logic        w_timed_state;
  logic        w_timeout;
  logic        w_load_done;
  logic        w_accept_pix;
  logic        w_err_pulse;
  logic [1:0]  w_err_code_next;

  assign w_product     = {8'd0, r_width} * {8'd0, r_height};
  assign w_size_bad    = (r_width == 8'd0) || (r_height == 8'd0) || ({1'b0, w_product} > MAX_P);
  assign w_timed_state = (r_state == S_GET_W) || (r_state == S_GET_H) || (r_state == S_LOAD);
  assign w_timeout     = w_timed_state && !i_Rx_DV && (r_to_cnt == TO_LAST);
  // Last byte accepted; this is the cycle its write is on the RAM port
  assign w_load_done   = (r_state == S_LOAD) && (r_cnt == r_pix_cnt);
  assign w_accept_pix  = (r_state == S_LOAD) && i_Rx_DV && (r_cnt < r_pix_cnt);

  always_comb begin
    w_state_next    = r_state;
    w_err_pulse     = 1'b0;
    w_err_code_next = r_err_code;
    case (r_state)
      S_IDLE:  if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) w_state_next = S_GET_W;
      S_GET_W: begin
        if (i_Rx_DV) w_state_next = S_GET_H;
        else if (w_timeout) begin
          w_state_next = S_IDLE; w_err_pulse = 1'b1; w_err_code_next = 2'b10;
        end
      end
      S_GET_H: begin
        if (i_Rx_DV) w_state_next = S_CHECK;
        else if (w_timeout) begin
          w_state_next = S_IDLE; w_err_pulse = 1'b1; w_err_code_next = 2'b10;
        end
      end
      S_CHECK: begin
        if (w_size_bad) begin
          w_state_next = S_IDLE; w_err_pulse = 1'b1; w_err_code_next = 2'b01;
        end else begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_load_done) w_state_next = S_START;
        else if (w_timeout) begin
          w_state_next = S_IDLE; w_err_pulse = 1'b1; w_err_code_next = 2'b10;
        end
      end
      S_START: w_state_next = S_BUSY;
      S_BUSY:  if (i_Proc_Done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Bytes with nowhere to go are dropped and flagged; a size error takes priority
    if (i_Rx_DV && !w_err_pulse &&
        ((r_state == S_CHECK) || (r_state == S_START) || (r_state == S_BUSY) || w_load_done)) begin
      w_err_pulse     = 1'b1;
      w_err_code_next = 2'b11;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_pix_cnt   <= '0;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_frame_err <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_frame_err <= w_err_pulse;
      r_err_code  <= w_err_code_next;
      r_wr_en     <= w_accept_pix;
      if (w_accept_pix) begin
        r_wr_addr <= r_cnt[ADDR_W-1:0];
        r_wr_data <= i_Rx_Byte;
        r_cnt     <= r_cnt + 16'd1;
      end
      if ((r_state == S_GET_W) && i_Rx_DV) r_width  <= i_Rx_Byte;
      if ((r_state == S_GET_H) && i_Rx_DV) r_height <= i_Rx_Byte;
      if (r_state == S_CHECK) begin
        r_pix_cnt <= w_product;
        r_cnt     <= '0;
      end
      if (w_timed_state && !i_Rx_DV && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
      else                                         r_to_cnt <= '0;
    end
  end

  assign o_Wr_En      = r_wr_en;
  assign o_Wr_Addr    = r_wr_addr;
  assign o_Wr_Data    = r_wr_data;
  assign o_Width      = r_width;
  assign o_Height     = r_height;
  assign o_Proc_Start = (r_state == S_START);
  assign o_Busy       = (r_state != S_IDLE);
  assign o_Frame_Err  = r_frame_err;
  assign o_Err_Code   = r_err_code;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: stimulus pushes expected writes, errors
// and start pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_uart_frame_loader;
  localparam int ADDR_W = 14;
  localparam int TOC    = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dv = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              done = 1'b0;
  logic              o_Wr_En;
  logic [ADDR_W-1:0] o_Wr_Addr;
  logic [7:0]        o_Wr_Data;
  logic [7:0]        o_Width;
  logic [7:0]        o_Height;
  logic              o_Proc_Start;
  logic              o_Busy;
  logic              o_Frame_Err;
  logic [1:0]        o_Err_Code;

  uart_frame_loader #(
    .SYNC_BYTE(8'hA5), .ADDR_W(ADDR_W), .MAX_PIXELS(16384), .TIMEOUT_CLKS(TOC)
  ) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(rx_byte),
    .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
    .o_Width(o_Width), .o_Height(o_Height), .o_Proc_Start(o_Proc_Start),
    .i_Proc_Done(done), .o_Busy(o_Busy), .o_Frame_Err(o_Frame_Err),
    .o_Err_Code(o_Err_Code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int code; } ev_t;
  wr_t wq[$];
  ev_t eq[$];
  int  sq[$];
  wr_t mw;
  ev_t me;
  int  ms;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event with value 0x%0h, expected none", name, act);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_start_overlap", int'(o_Wr_En & o_Proc_Start), 0);
      if (o_Wr_En) begin
        if (wq.size() == 0) unexpected("wr_unexpected", int'(o_Wr_Addr));
        else begin
          mw = wq.pop_front();
          $display("cyc %0d: write addr=%0d data=%02h", cyc, o_Wr_Addr, o_Wr_Data);
          check("wr_cycle", cyc, mw.cyc);
          check("wr_addr", int'(o_Wr_Addr), mw.addr);
          check("wr_data", int'(o_Wr_Data), mw.data);
        end
      end
      if (o_Frame_Err) begin
        if (eq.size() == 0) unexpected("err_unexpected", int'(o_Err_Code));
        else begin
          me = eq.pop_front();
          $display("cyc %0d: frame error code=%0d", cyc, o_Err_Code);
          check("err_cycle", cyc, me.cyc);
          check("err_code", int'(o_Err_Code), me.code);
        end
      end
      if (o_Proc_Start) begin
        if (sq.size() == 0) unexpected("start_unexpected", cyc);
        else begin
          ms = sq.pop_front();
          $display("cyc %0d: proc start w=%0d h=%0d", cyc, o_Width, o_Height);
          check("start_cycle", cyc, ms);
        end
      end
    end
  end

  // pix_addr < 0: not a pixel. err_code != 0: expect that error err_dly cycles after the DV edge.
  task automatic send(input logic [7:0] b, input int pix_addr, input bit last,
                      input int err_code, input int err_dly);
    int c;
    @(negedge clk);
    c = cyc + 1;
    if (pix_addr >= 0) begin
      wq.push_back('{c, pix_addr, int'(b)});
      if (last) sq.push_back(c + 1);
    end
    if (err_code != 0) eq.push_back('{c + err_dly, err_code});
    rx_byte = b;
    dv      = 1'b1;
    @(negedge clk);
    dv      = 1'b0;
  endtask

  task automatic frame(input logic [7:0] w, input logic [7:0] h, input logic [7:0] base,
                       input int n_send);
    int total;
    total = int'(w) * int'(h);
    send(8'hA5, -1, 1'b0, 0, 0);
    send(w, -1, 1'b0, 0, 0);
    send(h, -1, 1'b0, 0, 0);
    for (int i = 0; i < n_send; i++)
      send(8'(int'(base) + i), i, (i == total - 1), 0, 0);
  endtask

  task automatic finish_proc();
    repeat (3) @(negedge clk);
    check("busy_before_done", int'(o_Busy), 1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("busy_after_done", int'(o_Busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_wr_bus", int'({o_Wr_En, o_Wr_Addr, o_Wr_Data}), 0);
    check("reset_ctrl", int'({o_Width, o_Height, o_Proc_Start, o_Busy, o_Frame_Err, o_Err_Code}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 4x2 frame, pixels 10..17
    frame(8'd4, 8'd2, 8'h10, 8);
    check("width_4x2", int'(o_Width), 4);
    check("height_4x2", int'(o_Height), 2);
    finish_proc();

    // junk bytes in IDLE, then 2x2 frame whose first pixel equals the sync byte
    send(8'h00, -1, 1'b0, 0, 0);
    send(8'hFF, -1, 1'b0, 0, 0);
    send(8'h5A, -1, 1'b0, 0, 0);
    send(8'hA5, -1, 1'b0, 0, 0);
    send(8'h02, -1, 1'b0, 0, 0);
    send(8'h02, -1, 1'b0, 0, 0);
    send(8'hA5, 0, 1'b0, 0, 0);
    send(8'h01, 1, 1'b0, 0, 0);
    send(8'h02, 2, 1'b0, 0, 0);
    send(8'h03, 3, 1'b1, 0, 0);
    finish_proc();
    check("err_code_still_zero", int'(o_Err_Code), 0);

    // size errors: zero width, then 200*100 = 20000 > 16384
    send(8'hA5, -1, 1'b0, 0, 0);
    send(8'h00, -1, 1'b0, 0, 0);
    send(8'h05, -1, 1'b0, 1, 1);
    repeat (3) @(negedge clk);
    check("busy_after_size0", int'(o_Busy), 0);
    send(8'hA5, -1, 1'b0, 0, 0);
    send(8'hC8, -1, 1'b0, 0, 0);
    send(8'h64, -1, 1'b0, 1, 1);
    repeat (3) @(negedge clk);
    check("busy_after_size_big", int'(o_Busy), 0);
    check("err_code_hold_size", int'(o_Err_Code), 1);
    check("width_latched_c8", int'(o_Width), 200);

    // timeout: 3 of 9 pixels then silence
    send(8'hA5, -1, 1'b0, 0, 0);
    send(8'h03, -1, 1'b0, 0, 0);
    send(8'h03, -1, 1'b0, 0, 0);
    send(8'h30, 0, 1'b0, 0, 0);
    send(8'h31, 1, 1'b0, 0, 0);
    send(8'h32, 2, 1'b0, 2, TOC);
    repeat (TOC + 5) @(negedge clk);
    check("busy_after_timeout", int'(o_Busy), 0);
    check("err_code_timeout", int'(o_Err_Code), 2);
    frame(8'd1, 8'd2, 8'h60, 2);
    finish_proc();

    // overrun while the core is busy
    frame(8'd1, 8'd1, 8'h77, 1);
    repeat (3) @(negedge clk);
    send(8'h55, -1, 1'b0, 3, 0);
    check("err_code_overrun", int'(o_Err_Code), 3);
    finish_proc();

    // asynchronous reset mid-frame, then a full 4x4 frame
    frame(8'd4, 8'd4, 8'h80, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_wr_bus", int'({o_Wr_En, o_Wr_Addr, o_Wr_Data}), 0);
    check("midreset_ctrl", int'({o_Width, o_Height, o_Proc_Start, o_Busy, o_Frame_Err, o_Err_Code}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame(8'd4, 8'd4, 8'h40, 16);
    check("width_4x4", int'(o_Width), 4);
    check("height_4x4", int'(o_Height), 4);
    finish_proc();

    repeat (5) @(negedge clk);
    check("writes_outstanding", wq.size(), 0);
    check("errors_outstanding", eq.size(), 0);
    check("starts_outstanding", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
